// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one request strobe latches a byte, which is shifted out LSB first.
// Each bit is held for CLK_FRE/BAUD clock cycles; strobes arriving mid-frame are dropped.
module uart_tx #(
    parameter int BAUD    = 9600,
    parameter int CLK_FRE = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       data_flag,
    output logic       tx,
    output logic       busy
);

    localparam int BIT_CYC = CLK_FRE / BAUD;
    localparam int BAUD_W  = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int BIT_W   = $clog2(10);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYC - 1);
    localparam logic [BIT_W-1:0]  BIT_STOP  = BIT_W'(9);
    localparam logic [BIT_W-1:0]  BIT_LAST_DATA = BIT_W'(8);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [7:0]        shr_q, shr_d;
    logic              tx_q, tx_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        shr_d      = shr_q;
        tx_d       = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (data_flag) begin
                    state_d    = SEND;
                    shr_d      = data;
                    tx_d       = 1'b0;
                    bit_cnt_d  = '0;
                    baud_cnt_d = '0;
                end
            end
            SEND: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == BIT_STOP) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        // Frame slots 0..7 end by presenting the next data bit; slot 8 ends into the stop bit.
                        if (bit_cnt_q < BIT_LAST_DATA) begin
                            tx_d  = shr_q[0];
                            shr_d = {1'b0, shr_q[7:1]};
                        end else begin
                            tx_d = 1'b1;
                        end
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            shr_q      <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            shr_q      <= shr_d;
            tx_q       <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q == SEND);

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at a reduced clock so each bit lasts 10 cycles (100_000/9600, truncated).
module tb_uart_tx;

    localparam int BAUD    = 9600;
    localparam int CLK_FRE = 100_000;
    localparam int B       = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       data_flag;
    logic       tx;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    uart_tx #(.BAUD(BAUD), .CLK_FRE(CLK_FRE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .data_flag (data_flag),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; the strobe is seen by the next posedge only.
    task automatic flag(input logic [7:0] d);
        sb.push_back(d);
        data      = d;
        data_flag = 1'b1;
        @(negedge clk);
        data_flag = 1'b0;
        data      = ~d;
    endtask

    task automatic rx_frame();
        int         wait_c  = 0;
        int         glitch  = 0;
        int         busy_lo = 0;
        logic [9:0] bits    = '0;
        while (tx !== 1'b0 && wait_c < 4*B) begin
            @(negedge clk);
            wait_c++;
        end
        chk("start_lat", wait_c, 0);
        if (wait_c >= 4*B) return;
        for (int k = 0; k < 10*B; k++) begin
            if (k % B == 0) bits[k/B] = tx;
            else if (tx !== bits[k/B]) glitch++;
            if (busy !== 1'b1) busy_lo++;
            @(negedge clk);
        end
        chk("start_bit", bits[0], 0);
        chk("stop_bit", bits[9], 1);
        chk("bit_glitch", glitch, 0);
        chk("busy_hi", busy_lo, 0);
        chk("idle_tx", tx, 1);
        chk("idle_busy", busy, 0);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) chk("byte", bits[8:1], sb.pop_front());
    endtask

    task automatic quiet(input string tag, input int cycles);
        int bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        data      = 8'h00;
        data_flag = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);

        // Strobe present in the very first clocked cycle after reset release.
        sb.push_back(8'h00);
        data      = 8'h00;
        data_flag = 1'b1;
        rst_n     = 1'b1;
        @(negedge clk);
        data_flag = 1'b0;
        data      = 8'hFF;
        rx_frame();

        flag(8'h01); rx_frame();
        flag(8'h02); rx_frame();
        flag(8'h03); rx_frame();
        flag(8'h04); rx_frame();

        // Strobe during a frame must be dropped, not queued.
        flag(8'hA5);
        fork
            rx_frame();
            begin
                repeat (3*B) @(negedge clk);
                data      = 8'hFF;
                data_flag = 1'b1;
                @(negedge clk);
                data_flag = 1'b0;
            end
        join
        quiet("no_2nd_frame", 12*B);

        // Abort mid-frame: frame slot 4 carries data[3]=0 of 0x55.
        data      = 8'h55;
        data_flag = 1'b1;
        @(negedge clk);
        data_flag = 1'b0;
        repeat (4*B + B/2) @(negedge clk);
        chk("pre_rst_tx", tx, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet("post_abort_quiet", 12*B);

        flag(8'hC3); rx_frame();
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
